// File: rtl/idct_block_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : idct_block_scheduler_pkg
// Brief   : State encoding, plane codes and block coordinate type for the
//           IDCT block scheduler.
// Revision: 1.0
// ============================================================================
package idct_block_scheduler_pkg;

  localparam int c_PLANE_W = 2;
  localparam int c_ROW_W   = 5;
  localparam int c_COL_W   = 6;

  localparam logic [c_PLANE_W-1:0] c_PLANE_Y = 2'd0;
  localparam logic [c_PLANE_W-1:0] c_PLANE_U = 2'd1;
  localparam logic [c_PLANE_W-1:0] c_PLANE_V = 2'd2;

  typedef struct packed {
    logic [c_PLANE_W-1:0] plane;
    logic [c_ROW_W-1:0]   row;
    logic [c_COL_W-1:0]   col;
  } blk_coord_t;

  typedef enum logic [2:0] {
    S_SCH_IDLE   = 3'd0,
    S_SCH_LI_FS  = 3'd1,
    S_SCH_LI_CT  = 3'd2,
    S_SCH_MEGA_A = 3'd3,
    S_SCH_MEGA_B = 3'd4,
    S_SCH_LO_WS  = 3'd5,
    S_SCH_DONE   = 3'd6
  } IDCT_SCHED_state_type;

endpackage
`default_nettype wire

// File: rtl/idct_block_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : idct_block_scheduler_if
// Brief   : Control, engine handshake and coordinate bundle of the scheduler.
// Revision: 1.0
// ============================================================================
interface idct_block_scheduler_if;
  logic       start;
  logic       done;
  logic       busy;
  logic       FS_start;
  logic       FS_done;
  logic       CT_start;
  logic       CT_done;
  logic       CS_start;
  logic       CS_done;
  logic       WS_start;
  logic       WS_done;
  logic [1:0] fs_plane;
  logic [4:0] fs_row;
  logic [5:0] fs_col;
  logic [1:0] ws_plane;
  logic [4:0] ws_row;
  logic [5:0] ws_col;
  logic       protocol_err;

  modport master (
    input  start, FS_done, CT_done, CS_done, WS_done,
    output done, busy, FS_start, CT_start, CS_start, WS_start,
           fs_plane, fs_row, fs_col, ws_plane, ws_row, ws_col, protocol_err
  );

  modport slave (
    output start, FS_done, CT_done, CS_done, WS_done,
    input  done, busy, FS_start, CT_start, CS_start, WS_start,
           fs_plane, fs_row, fs_col, ws_plane, ws_row, ws_col, protocol_err
  );
endinterface
`default_nettype wire

// File: rtl/idct_block_scheduler_block_coord_counter.sv
`default_nettype none
// ============================================================================
// Module  : block_coord_counter
// Brief   : Plane/row/col block stepper, Y then U then V, row-major per plane.
// Revision: 1.0
// ============================================================================
module block_coord_counter
  import idct_block_scheduler_pkg::*;
#(
  parameter int ROW_BLOCKS    = 30,
  parameter int Y_COL_BLOCKS  = 40,
  parameter int UV_COL_BLOCKS = 20
) (
  input  wire logic   CLOCK_50_I,
  input  wire logic   Reset,
  input  wire logic   step,
  input  wire logic   clear,
  output blk_coord_t  coord,
  output logic        is_last
);

  blk_coord_t           r_coord;
  logic [c_COL_W-1:0]   w_col_max;
  logic                 w_col_end;
  logic                 w_row_end;

  assign w_col_max = (r_coord.plane == c_PLANE_Y) ? c_COL_W'(Y_COL_BLOCKS - 1)
                                                  : c_COL_W'(UV_COL_BLOCKS - 1);
  assign w_col_end = (r_coord.col == w_col_max);
  assign w_row_end = (r_coord.row == c_ROW_W'(ROW_BLOCKS - 1));
  assign is_last   = (r_coord.plane == c_PLANE_V) && w_row_end && w_col_end;
  assign coord     = r_coord;

  // Stepping past the last block wraps to the origin; the scheduler stops
  // issuing fetches once it has seen is_last.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      r_coord <= '0;
    end else if (clear) begin
      r_coord <= '0;
    end else if (step) begin
      if (is_last) begin
        r_coord <= '0;
      end else if (!w_col_end) begin
        r_coord.col <= r_coord.col + 1'b1;
      end else begin
        r_coord.col <= '0;
        if (!w_row_end) begin
          r_coord.row <= r_coord.row + 1'b1;
        end else begin
          r_coord.row   <= '0;
          r_coord.plane <= r_coord.plane + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/idct_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : idct_block_scheduler
// Brief   : Sequences FS/CT/CS/WS engines over every 8x8 block, overlapping
//           FS(n+1) with CS(n) and WS(n) with CT(n+1).
// Revision: 1.0
// ============================================================================
module idct_block_scheduler
  import idct_block_scheduler_pkg::*;
#(
  parameter int ROW_BLOCKS    = 30,
  parameter int Y_COL_BLOCKS  = 40,
  parameter int UV_COL_BLOCKS = 20
) (
  input wire logic              CLOCK_50_I,
  input wire logic              Reset,
  idct_block_scheduler_if.master sch
);

  IDCT_SCHED_state_type r_state, w_state_next;

  logic       r_fs_dl, r_ct_dl, r_cs_dl, r_ws_dl;
  logic       r_fetched_all;
  logic       r_fs_start, r_ct_start, r_cs_start, r_ws_start;
  logic       r_done, r_busy, r_protocol_err;
  blk_coord_t w_fs, r_fs_prev, r_ws;
  logic       w_fs_last;
  logic       w_fs_ok, w_ct_ok, w_cs_ok, w_ws_ok;
  logic       w_fs_fly, w_ct_fly, w_cs_fly, w_ws_fly;
  logic       w_leave_fs, w_ct_cmp, w_trans, w_clear, w_spurious;

  block_coord_counter #(
    .ROW_BLOCKS    (ROW_BLOCKS),
    .Y_COL_BLOCKS  (Y_COL_BLOCKS),
    .UV_COL_BLOCKS (UV_COL_BLOCKS)
  ) u_fs_coord (
    .CLOCK_50_I (CLOCK_50_I),
    .Reset      (Reset),
    .step       (w_leave_fs),
    .clear      (w_clear),
    .coord      (w_fs),
    .is_last    (w_fs_last)
  );

  assign w_fs_ok = r_fs_dl | sch.FS_done;
  assign w_ct_ok = r_ct_dl | sch.CT_done;
  assign w_cs_ok = r_cs_dl | sch.CS_done;
  assign w_ws_ok = r_ws_dl | sch.WS_done;

  assign w_fs_fly = ((r_state == S_SCH_LI_FS) ||
                     ((r_state == S_SCH_MEGA_A) && !r_fetched_all)) && !r_fs_dl;
  assign w_ct_fly = ((r_state == S_SCH_LI_CT) || (r_state == S_SCH_MEGA_B)) && !r_ct_dl;
  assign w_cs_fly = (r_state == S_SCH_MEGA_A) && !r_cs_dl;
  assign w_ws_fly = ((r_state == S_SCH_MEGA_B) || (r_state == S_SCH_LO_WS)) && !r_ws_dl;

  assign w_spurious = (sch.FS_done && !w_fs_fly) || (sch.CT_done && !w_ct_fly) ||
                      (sch.CS_done && !w_cs_fly) || (sch.WS_done && !w_ws_fly);

  assign w_clear = (r_state == S_SCH_IDLE) && sch.start;
  assign w_trans = (w_state_next != r_state);

  always_comb begin
    w_state_next = r_state;
    w_leave_fs   = 1'b0;
    w_ct_cmp     = 1'b0;
    case (r_state)
      S_SCH_IDLE:   if (sch.start) w_state_next = S_SCH_LI_FS;
      S_SCH_LI_FS:  if (w_fs_ok) begin
                      w_state_next = S_SCH_LI_CT;
                      w_leave_fs   = 1'b1;
                    end
      S_SCH_LI_CT:  if (w_ct_ok) begin
                      w_state_next = S_SCH_MEGA_A;
                      w_ct_cmp     = 1'b1;
                    end
      S_SCH_MEGA_A: if (r_fetched_all) begin
                      if (w_cs_ok) w_state_next = S_SCH_LO_WS;
                    end else if (w_cs_ok && w_fs_ok) begin
                      w_state_next = S_SCH_MEGA_B;
                      w_leave_fs   = 1'b1;
                    end
      S_SCH_MEGA_B: if (w_ct_ok && w_ws_ok) begin
                      w_state_next = S_SCH_MEGA_A;
                      w_ct_cmp     = 1'b1;
                    end
      S_SCH_LO_WS:  if (w_ws_ok) w_state_next = S_SCH_DONE;
      S_SCH_DONE:   w_state_next = S_SCH_IDLE;
      default:      w_state_next = S_SCH_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) r_state <= S_SCH_IDLE;
    else       r_state <= w_state_next;
  end

  // Done-latches live only for the duration of one state.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      {r_fs_dl, r_ct_dl, r_cs_dl, r_ws_dl} <= '0;
    end else if (w_trans) begin
      {r_fs_dl, r_ct_dl, r_cs_dl, r_ws_dl} <= '0;
    end else begin
      if (sch.FS_done && w_fs_fly) r_fs_dl <= 1'b1;
      if (sch.CT_done && w_ct_fly) r_ct_dl <= 1'b1;
      if (sch.CS_done && w_cs_fly) r_cs_dl <= 1'b1;
      if (sch.WS_done && w_ws_fly) r_ws_dl <= 1'b1;
    end
  end

  // Start pulses fire on state entry only, so an engine is never re-kicked.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      r_fs_start     <= 1'b0;
      r_ct_start     <= 1'b0;
      r_cs_start     <= 1'b0;
      r_ws_start     <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_fs_start <= w_trans && ((w_state_next == S_SCH_LI_FS) ||
                                ((w_state_next == S_SCH_MEGA_A) && !r_fetched_all));
      r_ct_start <= w_trans && ((w_state_next == S_SCH_LI_CT) || (w_state_next == S_SCH_MEGA_B));
      r_cs_start <= w_trans && (w_state_next == S_SCH_MEGA_A);
      r_ws_start <= w_trans && ((w_state_next == S_SCH_MEGA_B) || (w_state_next == S_SCH_LO_WS));
      r_done     <= w_trans && (w_state_next == S_SCH_DONE);
      r_busy     <= (w_state_next != S_SCH_IDLE) && (w_state_next != S_SCH_DONE);
      r_protocol_err <= r_protocol_err | w_spurious;
    end
  end

  // ws trails fs by one block: r_fs_prev holds the block most recently fetched.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      r_fetched_all <= 1'b0;
      r_fs_prev     <= '0;
      r_ws          <= '0;
    end else if (w_clear) begin
      r_fetched_all <= 1'b0;
      r_fs_prev     <= '0;
      r_ws          <= '0;
    end else begin
      if (w_leave_fs) begin
        r_fs_prev <= w_fs;
        if (w_fs_last) r_fetched_all <= 1'b1;
      end
      if (w_ct_cmp) r_ws <= r_fs_prev;
    end
  end

  assign sch.FS_start     = r_fs_start;
  assign sch.CT_start     = r_ct_start;
  assign sch.CS_start     = r_cs_start;
  assign sch.WS_start     = r_ws_start;
  assign sch.done         = r_done;
  assign sch.busy         = r_busy;
  assign sch.protocol_err = r_protocol_err;
  assign sch.fs_plane     = w_fs.plane;
  assign sch.fs_row       = w_fs.row;
  assign sch.fs_col       = w_fs.col;
  assign sch.ws_plane     = r_ws.plane;
  assign sch.ws_row       = r_ws.row;
  assign sch.ws_col       = r_ws.col;

endmodule
`default_nettype wire

// File: tb/tb_idct_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_idct_block_scheduler
// Brief   : Scoreboard bench for the IDCT block scheduler (2x(2+2*1) = 8 blocks).
// Revision: 1.0
// ============================================================================
module tb_idct_block_scheduler;

  localparam int c_ROW  = 2;
  localparam int c_YC   = 2;
  localparam int c_UVC  = 1;
  localparam int c_NBLK = c_ROW * (c_YC + 2 * c_UVC);

  logic CLOCK_50_I = 1'b0;
  logic Reset      = 1'b1;

  idct_block_scheduler_if sif ();

  idct_block_scheduler #(
    .ROW_BLOCKS    (c_ROW),
    .Y_COL_BLOCKS  (c_YC),
    .UV_COL_BLOCKS (c_UVC)
  ) dut (
    .CLOCK_50_I (CLOCK_50_I),
    .Reset      (Reset),
    .sch        (sif)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  // Engine index: 3=FS 2=CT 1=CS 0=WS
  int         dly [4];
  int         cnt [4];
  logic [3:0] resp_done = '0;
  logic [3:0] inj       = '0;

  wire [3:0]  w_starts = {sif.FS_start, sif.CT_start, sif.CS_start, sif.WS_start};
  wire [3:0]  w_dones  = {sif.FS_done, sif.CT_done, sif.CS_done, sif.WS_done};
  wire [6:0]  w_ctrl   = {sif.done, sif.busy, sif.protocol_err, w_starts};
  wire [12:0] w_fs     = {sif.fs_plane, sif.fs_row, sif.fs_col};
  wire [12:0] w_ws     = {sif.ws_plane, sif.ws_row, sif.ws_col};

  assign sif.FS_done = resp_done[3] | inj[3];
  assign sif.CT_done = resp_done[2] | inj[2];
  assign sif.CS_done = resp_done[1] | inj[1];
  assign sif.WS_done = resp_done[0] | inj[0];

  int n_cmp = 0;
  int n_err = 0;
  int n_fs, n_ct, n_cs, n_ws, n_done;
  bit mon_en = 1'b0;

  logic [3:0]  q_ord [$];
  logic [12:0] q_fs  [$];
  logic [12:0] q_ws  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engines answer done dly[e] cycles after their start pulse.
  initial begin
    dly = '{3, 3, 3, 3};
    cnt = '{0, 0, 0, 0};
    forever begin
      @(posedge CLOCK_50_I);
      #1;
      for (int e = 0; e < 4; e++) begin
        resp_done[e] = 1'b0;
        if (Reset) begin
          cnt[e] = 0;
        end else begin
          if (cnt[e] > 0) begin
            cnt[e]--;
            if (cnt[e] == 0) resp_done[e] = 1'b1;
          end
          if (w_starts[e]) cnt[e] = dly[e];
        end
      end
    end
  end

  // Monitor: pops expected start groups and coordinates as the DUT issues them.
  initial begin
    logic [3:0] fly;
    logic       prev_busy;
    fly = '0;
    prev_busy = 1'b0;
    forever begin
      @(negedge CLOCK_50_I);
      if (Reset) begin
        fly = '0;
      end else if (mon_en) begin
        fly = fly & ~w_dones;
        if (w_starts != 4'b0) begin
          check("start_in_flight", w_starts & fly, 0);
          fly = fly | w_starts;
          if (q_ord.size() == 0) check("order_extra", w_starts, 0);
          else                   check("order", w_starts, q_ord.pop_front());
        end
        if (sif.FS_start) begin
          n_fs++;
          if (q_fs.size() == 0) check("fs_coord_extra", 1, 0);
          else                  check("fs_coord", w_fs, q_fs.pop_front());
        end
        if (sif.WS_start) begin
          n_ws++;
          if (q_ws.size() == 0) check("ws_coord_extra", 1, 0);
          else                  check("ws_coord", w_ws, q_ws.pop_front());
        end
        if (sif.CT_start) n_ct++;
        if (sif.CS_start) n_cs++;
        if (sif.done) begin
          n_done++;
          check("done_busy_low", sif.busy, 0);
          check("busy_before_done", prev_busy, 1);
        end
      end
      prev_busy = sif.busy;
    end
  end

  task automatic load_sb();
    int ncol;
    q_ord.delete();
    q_fs.delete();
    q_ws.delete();
    q_ord.push_back(4'b1000);
    q_ord.push_back(4'b0100);
    for (int i = 1; i < c_NBLK; i++) begin
      q_ord.push_back(4'b1010);
      q_ord.push_back(4'b0101);
    end
    q_ord.push_back(4'b0010);
    q_ord.push_back(4'b0001);
    for (int p = 0; p < 3; p++) begin
      ncol = (p == 0) ? c_YC : c_UVC;
      for (int r = 0; r < c_ROW; r++)
        for (int c = 0; c < ncol; c++) begin
          q_fs.push_back({2'(p), 5'(r), 6'(c)});
          q_ws.push_back({2'(p), 5'(r), 6'(c)});
        end
    end
    n_fs = 0; n_ct = 0; n_cs = 0; n_ws = 0; n_done = 0;
    mon_en = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge CLOCK_50_I); #1 sif.start = 1'b1;
    @(posedge CLOCK_50_I); #1 sif.start = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    bit got_done;
    got_done = 1'b0;
    load_sb();
    pulse_start();
    @(negedge CLOCK_50_I);
    check({tag, "_busy_rise"}, sif.busy, 1);
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge CLOCK_50_I);
      if (sif.done) got_done = 1'b1;
    end
    check({tag, "_done_seen"}, got_done, 1);
    repeat (6) @(negedge CLOCK_50_I);
    check({tag, "_n_fs"}, n_fs, c_NBLK);
    check({tag, "_n_ct"}, n_ct, c_NBLK);
    check({tag, "_n_cs"}, n_cs, c_NBLK);
    check({tag, "_n_ws"}, n_ws, c_NBLK);
    check({tag, "_n_done"}, n_done, 1);
    check({tag, "_sb_left"}, q_ord.size() + q_fs.size() + q_ws.size(), 0);
    check({tag, "_busy_end"}, sif.busy, 0);
  endtask

  // Simultaneous CS_done/FS_done: CT+WS start exactly one cycle later.
  task automatic t2_check();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLOCK_50_I);
      if (sif.CS_done && sif.FS_done) seen = 1'b1;
    end
    check("t2_dones_together", seen, 1);
    @(negedge CLOCK_50_I);
    check("t2_k1_starts", w_starts, 4'b0101);
    @(negedge CLOCK_50_I);
    check("t2_k2_starts", w_starts, 4'b0000);
  endtask

  // FS_done well ahead of CS_done: nothing new issues until CS_done.
  task automatic t3_check();
    bit seen_cs, seen_csd;
    int fs_cnt, ct_cnt, fsd_cnt;
    seen_cs = 1'b0; seen_csd = 1'b0;
    fs_cnt = 0; ct_cnt = 0; fsd_cnt = 0;
    for (int i = 0; i < 200 && !seen_cs; i++) begin
      @(negedge CLOCK_50_I);
      if (sif.CS_start) seen_cs = 1'b1;
    end
    check("t3_cs_start_seen", seen_cs, 1);
    for (int i = 0; i < 60 && !seen_csd; i++) begin
      @(negedge CLOCK_50_I);
      if (sif.CS_done) seen_csd = 1'b1;
      else begin
        fs_cnt  += int'(sif.FS_start);
        ct_cnt  += int'(sif.CT_start);
        fsd_cnt += int'(sif.FS_done);
      end
    end
    check("t3_cs_done_seen", seen_csd, 1);
    check("t3_fs_done_early", fsd_cnt, 1);
    check("t3_no_dup_fs", fs_cnt, 0);
    check("t3_no_early_ct", ct_cnt, 0);
    @(negedge CLOCK_50_I);
    check("t3_ct_after_cs", sif.CT_start, 1);
  endtask

  // Spurious WS_done plus a second start while in LI_CT.
  task automatic t6_inject();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLOCK_50_I);
      if (sif.CT_start) seen = 1'b1;
    end
    check("t6_lict_seen", seen, 1);
    check("t6_perr_before", sif.protocol_err, 0);
    @(posedge CLOCK_50_I); #1 inj[0] = 1'b1; sif.start = 1'b1;
    @(posedge CLOCK_50_I); #1 inj[0] = 1'b0; sif.start = 1'b0;
    @(negedge CLOCK_50_I);
    check("t6_perr_set", sif.protocol_err, 1);
  endtask

  initial begin
    int mb;
    sif.start = 1'b0;
    Reset     = 1'b1;
    repeat (3) @(negedge CLOCK_50_I);
    check("reset_ctrl", w_ctrl, 0);
    check("reset_coords", {w_fs, w_ws}, 0);
    Reset = 1'b0;
    repeat (2) @(negedge CLOCK_50_I);

    fork
      run_frame("t1");
      t2_check();
    join
    check("t1_perr", sif.protocol_err, 0);

    dly[1] = 13;
    fork
      run_frame("t3");
      t3_check();
    join
    dly[1] = 3;

    // Abort mid-frame in the second MEGA_B, then replay a full frame.
    load_sb();
    pulse_start();
    mb = 0;
    for (int i = 0; i < 300 && mb < 2; i++) begin
      @(negedge CLOCK_50_I);
      if (sif.CT_start && sif.WS_start) mb++;
    end
    check("t5_mega_b_reached", mb, 2);
    mon_en = 1'b0;
    Reset  = 1'b1;
    #1;
    check("t5_async_ctrl", w_ctrl, 0);
    check("t5_async_coords", {w_fs, w_ws}, 0);
    repeat (2) @(negedge CLOCK_50_I);
    Reset = 1'b0;
    repeat (3) @(negedge CLOCK_50_I);
    check("t5_idle_after_reset", w_ctrl, 0);
    run_frame("t5");

    fork
      run_frame("t6");
      t6_inject();
    join
    check("t6_perr_sticky", sif.protocol_err, 1);
    @(negedge CLOCK_50_I);
    Reset = 1'b1;
    #1;
    check("t6_perr_cleared", sif.protocol_err, 0);
    repeat (2) @(negedge CLOCK_50_I);
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
